gcd_arbiter: RTL and testbench

Round-robin arbiter and sequencer that shares one gcd_engine among N requesters. It selects a pending requester, loads its operands into the engine, drives the start/ready handshake, captures the result and returns it to the winning requester. A watchdog aborts a transaction if the engine never returns to ready. It sits between the requester clients and a single gcd_engine instance.

---
 rtl/gcd_arbiter.sv | 196 +++++++++++++++++++
 tb/tb_gcd_arbiter.sv | 407 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/gcd_arbiter.sv
// Round-robin arbiter that shares one gcd_engine among N requesters.
// It sequences the engine start/ready handshake, returns each result to its owner, and aborts a transaction after TIMEOUT cycles.
module gcd_arbiter #(
  parameter int N       = 4,
  parameter int W       = 7,
  parameter int TIMEOUT = 511
) (
  input  logic           clk,
  input  logic           reset,
  input  logic [N-1:0]   req,
  input  logic [N*W-1:0] a_bus,
  input  logic [N*W-1:0] b_bus,
  output logic [N-1:0]   grant,
  output logic [N-1:0]   done,
  output logic [W-1:0]   result,
  output logic           err,
  output logic           busy,
  output logic           eng_start,
  output logic [W-1:0]   eng_a,
  output logic [W-1:0]   eng_b,
  input  logic           eng_ready,
  input  logic [W-1:0]   eng_r
);

  localparam int IW = (N > 1) ? $clog2(N) : 1;
  localparam int CW = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    WAIT_BUSY,
    WAIT_DONE,
    DONE
  } state_t;

  state_t        state_q, state_d;
  logic [IW-1:0] rr_ptr_q, rr_ptr_d;
  logic [IW-1:0] owner_q, owner_d;
  logic [CW-1:0] wd_cnt_q, wd_cnt_d;
  logic [N-1:0]  grant_q, grant_d;
  logic [N-1:0]  done_q, done_d;
  logic [W-1:0]  result_q, result_d;
  logic [W-1:0]  eng_a_q, eng_a_d;
  logic [W-1:0]  eng_b_q, eng_b_d;
  logic          err_q, err_d;
  logic          busy_q, busy_d;
  logic          eng_start_q, eng_start_d;

  logic [W-1:0]  a_arr [N];
  logic [W-1:0]  b_arr [N];
  logic          pick_valid;
  logic [IW-1:0] pick_idx;
  logic [IW-1:0] cand;
  logic          wd_expired;

  for (genvar g = 0; g < N; g++) begin : g_unpack
    assign a_arr[g] = a_bus[g*W +: W];
    assign b_arr[g] = b_bus[g*W +: W];
  end

  // Circular scan for the first pending request at or after rr_ptr.
  always_comb begin
    pick_valid = 1'b0;
    pick_idx   = '0;
    cand       = '0;
    for (int k = 0; k < N; k++) begin
      cand = IW'((int'(rr_ptr_q) + k) % N);
      if (!pick_valid && req[cand]) begin
        pick_valid = 1'b1;
        pick_idx   = cand;
      end
    end
  end

  assign wd_expired = (wd_cnt_q == CW'(TIMEOUT - 1));

  always_comb begin
    state_d     = state_q;
    rr_ptr_d    = rr_ptr_q;
    owner_d     = owner_q;
    wd_cnt_d    = wd_cnt_q;
    grant_d     = grant_q;
    done_d      = '0;
    result_d    = result_q;
    err_d       = 1'b0;
    eng_start_d = eng_start_q;
    eng_a_d     = eng_a_q;
    eng_b_d     = eng_b_q;

    unique case (state_q)
      IDLE: begin
        wd_cnt_d = '0;
        if (pick_valid) begin
          state_d           = ISSUE;
          owner_d           = pick_idx;
          grant_d           = '0;
          grant_d[pick_idx] = 1'b1;
          eng_a_d           = a_arr[pick_idx];
          eng_b_d           = b_arr[pick_idx];
          eng_start_d       = 1'b1;
        end
      end

      ISSUE: begin
        state_d     = WAIT_BUSY;
        eng_start_d = 1'b1;
        wd_cnt_d    = '0;
      end

      // Start stays high until the engine is seen busy, covering an engine still leaving reset.
      WAIT_BUSY: begin
        wd_cnt_d = wd_cnt_q + 1'b1;
        if (wd_expired) begin
          state_d     = DONE;
          eng_start_d = 1'b0;
          result_d    = '0;
          err_d       = 1'b1;
          done_d      = grant_q;
        end else if (!eng_ready) begin
          state_d     = WAIT_DONE;
          eng_start_d = 1'b0;
        end
      end

      // A result arriving on the expiry cycle takes priority over the abort.
      WAIT_DONE: begin
        wd_cnt_d    = wd_cnt_q + 1'b1;
        eng_start_d = 1'b0;
        if (eng_ready) begin
          state_d  = DONE;
          result_d = eng_r;
          done_d   = grant_q;
        end else if (wd_expired) begin
          state_d  = DONE;
          result_d = '0;
          err_d    = 1'b1;
          done_d   = grant_q;
        end
      end

      DONE: begin
        state_d  = IDLE;
        grant_d  = '0;
        rr_ptr_d = (owner_q == IW'(N - 1)) ? '0 : owner_q + 1'b1;
      end

      default: begin
        state_d     = IDLE;
        grant_d     = '0;
        eng_start_d = 1'b0;
      end
    endcase

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      rr_ptr_q    <= '0;
      owner_q     <= '0;
      wd_cnt_q    <= '0;
      grant_q     <= '0;
      done_q      <= '0;
      result_q    <= '0;
      err_q       <= 1'b0;
      busy_q      <= 1'b0;
      eng_start_q <= 1'b0;
      eng_a_q     <= '0;
      eng_b_q     <= '0;
    end else begin
      state_q     <= state_d;
      rr_ptr_q    <= rr_ptr_d;
      owner_q     <= owner_d;
      wd_cnt_q    <= wd_cnt_d;
      grant_q     <= grant_d;
      done_q      <= done_d;
      result_q    <= result_d;
      err_q       <= err_d;
      busy_q      <= busy_d;
      eng_start_q <= eng_start_d;
      eng_a_q     <= eng_a_d;
      eng_b_q     <= eng_b_d;
    end
  end

  assign grant     = grant_q;
  assign done      = done_q;
  assign result    = result_q;
  assign err       = err_q;
  assign busy      = busy_q;
  assign eng_start = eng_start_q;
  assign eng_a     = eng_a_q;
  assign eng_b     = eng_b_q;

endmodule

// File: tb/tb_gcd_arbiter.sv
// Testbench for gcd_arbiter: a behavioural engine stub plus a round-robin/GCD reference model.
// Covers table vectors, contention, fairness, watchdog boundaries, mid-transaction reset and random traffic.
module tb_gcd_arbiter;

  localparam int N       = 4;
  localparam int W       = 7;
  localparam int TIMEOUT = 511;

  logic           clk = 1'b0;
  logic           reset;
  logic [N-1:0]   req;
  logic [N*W-1:0] a_bus;
  logic [N*W-1:0] b_bus;
  logic [N-1:0]   grant;
  logic [N-1:0]   done;
  logic [W-1:0]   result;
  logic           err;
  logic           busy;
  logic           eng_start;
  logic [W-1:0]   eng_a;
  logic [W-1:0]   eng_b;
  logic           eng_ready;
  logic [W-1:0]   eng_r;

  logic [W-1:0]   a_op [N];
  logic [W-1:0]   b_op [N];

  int tests;
  int fails;
  int m_rr;

  logic           stub_stuck;
  int             stub_lat_force;
  int             stub_cnt;
  logic [W-1:0]   stub_a;
  logic [W-1:0]   stub_b;

  gcd_arbiter #(.N(N), .W(W), .TIMEOUT(TIMEOUT)) dut (
    .clk       (clk),
    .reset     (reset),
    .req       (req),
    .a_bus     (a_bus),
    .b_bus     (b_bus),
    .grant     (grant),
    .done      (done),
    .result    (result),
    .err       (err),
    .busy      (busy),
    .eng_start (eng_start),
    .eng_a     (eng_a),
    .eng_b     (eng_b),
    .eng_ready (eng_ready),
    .eng_r     (eng_r)
  );

  always #5 clk = ~clk;

  always_comb begin
    for (int i = 0; i < N; i++) begin
      a_bus[i*W +: W] = a_op[i];
      b_bus[i*W +: W] = b_op[i];
    end
  end

  function automatic logic [W-1:0] ref_gcd(input logic [W-1:0] a, input logic [W-1:0] b);
    int x, y, t;
    x = int'(a);
    y = int'(b);
    while (y != 0) begin
      t = x % y;
      x = y;
      y = t;
    end
    return W'(x);
  endfunction

  // Subtractive step count gives the stub a data-dependent busy time.
  function automatic int eng_latency(input logic [W-1:0] a, input logic [W-1:0] b);
    int x, y, steps;
    x = int'(a);
    y = int'(b);
    steps = 0;
    if (x == 0 || y == 0) return 1;
    while (x != y) begin
      if (x > y) x = x - y;
      else y = y - x;
      steps++;
    end
    return steps + 1;
  endfunction

  function automatic int model_pick(input logic [N-1:0] r, input int p);
    for (int k = 0; k < N; k++) begin
      if (r[(p + k) % N]) return (p + k) % N;
    end
    return -1;
  endfunction

  // Engine stub: accepts start while ready, drops ready, and shows garbage on r until it finishes.
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      eng_ready <= 1'b1;
      stub_cnt  <= 0;
      eng_r     <= '0;
      stub_a    <= '0;
      stub_b    <= '0;
    end else if (stub_stuck) begin
      eng_ready <= 1'b0;
      stub_cnt  <= 0;
      eng_r     <= W'($urandom);
    end else if (eng_ready) begin
      if (eng_start) begin
        eng_ready <= 1'b0;
        stub_cnt  <= (stub_lat_force > 0) ? stub_lat_force : eng_latency(eng_a, eng_b);
        stub_a    <= eng_a;
        stub_b    <= eng_b;
        eng_r     <= W'($urandom);
      end
    end else if (stub_cnt <= 1) begin
      eng_ready <= 1'b1;
      eng_r     <= ref_gcd(stub_a, stub_b);
    end else begin
      stub_cnt <= stub_cnt - 1;
      eng_r    <= W'($urandom);
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!reset) begin
      checkOutput("grant_onehot", 32'($onehot0(grant)), 32'd1);
      checkOutput("done_within_grant", 32'(done & ~grant), 32'd0);
      checkOutput("err_without_done", 32'(err && (done == '0)), 32'd0);
    end
  end

  // Runs one transaction to completion for whichever requester the model says wins.
  task automatic applyStimulus(input string tag, input bit hold, input bit exp_err,
                               output int served, output logic [W-1:0] got_res, output int gcyc);
    int idx, rise_cyc;
    bit seen;
    logic prev_ready;
    logic [N-1:0] exp_grant;
    idx = model_pick(req, m_rr);
    served = idx;
    got_res = '0;
    gcyc = 0;
    if (idx < 0) begin
      checkOutput({tag, "_no_request"}, 32'd0, 32'd1);
      return;
    end
    exp_grant = '0;
    exp_grant[idx] = 1'b1;
    seen = 1'b0;
    for (int n = 0; n < 10 && !seen; n++) begin
      @(negedge clk);
      seen = (grant != '0);
    end
    if (!seen) begin
      checkOutput({tag, "_grant_wait_expired"}, 32'd0, 32'd1);
      return;
    end
    checkOutput({tag, "_grant"}, 32'(grant), 32'(exp_grant));
    checkOutput({tag, "_start_in_issue"}, 32'(eng_start), 32'd1);
    checkOutput({tag, "_eng_a"}, 32'(eng_a), 32'(a_op[idx]));
    checkOutput({tag, "_eng_b"}, 32'(eng_b), 32'(b_op[idx]));
    checkOutput({tag, "_busy_in_issue"}, 32'(busy), 32'd1);
    seen = 1'b0;
    rise_cyc = -1;
    prev_ready = eng_ready;
    for (int n = 1; n <= TIMEOUT + 20 && !seen; n++) begin
      @(negedge clk);
      if (n == 1) checkOutput({tag, "_start_held"}, 32'(eng_start), 32'd1);
      if (done != '0) begin
        seen = 1'b1;
        gcyc = n;
      end else begin
        if (n == 2) checkOutput({tag, "_start_dropped"}, 32'(eng_start), 32'd0);
        if (eng_ready && !prev_ready && rise_cyc < 0) rise_cyc = n;
      end
      prev_ready = eng_ready;
    end
    if (!seen) begin
      checkOutput({tag, "_done_wait_expired"}, 32'd0, 32'd1);
      return;
    end
    checkOutput({tag, "_done"}, 32'(done), 32'(exp_grant));
    checkOutput({tag, "_grant_at_done"}, 32'(grant), 32'(exp_grant));
    checkOutput({tag, "_err"}, 32'(err), 32'(exp_err));
    checkOutput({tag, "_result"}, 32'(result), exp_err ? 32'd0 : 32'(ref_gcd(a_op[idx], b_op[idx])));
    checkOutput({tag, "_start_at_done"}, 32'(eng_start), 32'd0);
    if (!exp_err) checkOutput({tag, "_done_latency"}, 32'(gcyc), 32'(rise_cyc + 1));
    got_res = result;
    if (!hold) req[idx] = 1'b0;
    m_rr = (idx + 1) % N;
    @(negedge clk);
    checkOutput({tag, "_idle_busy"}, 32'(busy), 32'd0);
    checkOutput({tag, "_idle_grant"}, 32'(grant), 32'd0);
    checkOutput({tag, "_idle_done"}, 32'(done), 32'd0);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    m_rr = 0;
    @(negedge clk);
  endtask

  task automatic wait_engine_idle(input string tag);
    bit ok;
    ok = 1'b0;
    for (int n = 0; n < 1000 && !ok; n++) begin
      @(negedge clk);
      ok = eng_ready;
    end
    checkOutput({tag, "_engine_idle"}, 32'(ok), 32'd1);
  endtask

  typedef struct {
    int           idx;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] exp;
  } vec_t;

  vec_t vecs[8];
  int   served;
  int   cyc;
  logic [W-1:0] res;
  int   order_exp[4];
  logic [W-1:0] res_exp[4];
  int   fair_exp[6];
  bit   ok;

  initial begin
    tests = 0;
    fails = 0;
    m_rr = 0;
    req = '0;
    stub_stuck = 1'b0;
    stub_lat_force = 0;
    for (int i = 0; i < N; i++) begin
      a_op[i] = '0;
      b_op[i] = '0;
    end
    vecs[0] = '{1, 7'd48, 7'd36, 7'd12};
    vecs[1] = '{2, 7'd7, 7'd5, 7'd1};
    vecs[2] = '{3, 7'd0, 7'd9, 7'd9};
    vecs[3] = '{0, 7'd100, 7'd75, 7'd25};
    vecs[4] = '{1, 7'd127, 7'd1, 7'd1};
    vecs[5] = '{2, 7'd0, 7'd0, 7'd0};
    vecs[6] = '{3, 7'd9, 7'd0, 7'd9};
    vecs[7] = '{0, 7'd126, 7'd127, 7'd1};

    reset = 1'b1;
    repeat (2) @(negedge clk);
    checkOutput("reset_grant", 32'(grant), 32'd0);
    checkOutput("reset_done", 32'(done), 32'd0);
    checkOutput("reset_result", 32'(result), 32'd0);
    checkOutput("reset_err", 32'(err), 32'd0);
    checkOutput("reset_busy", 32'(busy), 32'd0);
    checkOutput("reset_start", 32'(eng_start), 32'd0);
    checkOutput("reset_eng_a", 32'(eng_a), 32'd0);
    checkOutput("reset_eng_b", 32'(eng_b), 32'd0);
    reset = 1'b0;
    @(negedge clk);
    checkOutput("idle_busy", 32'(busy), 32'd0);

    a_op[0] = 7'd12;
    b_op[0] = 7'd18;
    req = 4'b0001;
    applyStimulus("single", 1'b0, 1'b0, served, res, cyc);
    checkOutput("single_value", 32'(res), 32'd6);

    for (int v = 0; v < 8; v++) begin
      a_op[vecs[v].idx] = vecs[v].a;
      b_op[vecs[v].idx] = vecs[v].b;
      req[vecs[v].idx] = 1'b1;
      applyStimulus("table", 1'b0, 1'b0, served, res, cyc);
      checkOutput("table_owner", 32'(served), 32'(vecs[v].idx));
      checkOutput("table_value", 32'(res), 32'(vecs[v].exp));
    end

    do_reset();
    a_op[0] = 7'd48;  b_op[0] = 7'd36;
    a_op[1] = 7'd7;   b_op[1] = 7'd5;
    a_op[2] = 7'd0;   b_op[2] = 7'd9;
    a_op[3] = 7'd100; b_op[3] = 7'd75;
    order_exp = '{0, 1, 2, 3};
    res_exp = '{7'd12, 7'd1, 7'd9, 7'd25};
    req = 4'b1111;
    for (int k = 0; k < 4; k++) begin
      applyStimulus("contend", 1'b0, 1'b0, served, res, cyc);
      checkOutput("contend_order", 32'(served), 32'(order_exp[k]));
      checkOutput("contend_value", 32'(res), 32'(res_exp[k]));
    end

    do_reset();
    a_op[1] = 7'd30; b_op[1] = 7'd45;
    a_op[3] = 7'd64; b_op[3] = 7'd40;
    fair_exp = '{1, 3, 1, 3, 1, 3};
    req = 4'b1010;
    for (int k = 0; k < 6; k++) begin
      applyStimulus("fair", 1'b1, 1'b0, served, res, cyc);
      checkOutput("fair_order", 32'(served), 32'(fair_exp[k]));
    end
    req = '0;
    repeat (2) @(negedge clk);
    checkOutput("fair_quiet_busy", 32'(busy), 32'd0);

    a_op[2] = 7'd50; b_op[2] = 7'd20;
    req = 4'b0100;
    applyStimulus("hold_first", 1'b1, 1'b0, served, res, cyc);
    checkOutput("hold_first_owner", 32'(served), 32'd2);
    applyStimulus("hold_again", 1'b0, 1'b0, served, res, cyc);
    checkOutput("hold_again_owner", 32'(served), 32'd2);
    @(negedge clk);
    checkOutput("dropped_busy", 32'(busy), 32'd0);
    checkOutput("dropped_grant", 32'(grant), 32'd0);

    wait_engine_idle("pre_stuck");
    stub_stuck = 1'b1;
    a_op[0] = 7'd33; b_op[0] = 7'd22;
    req = 4'b0001;
    applyStimulus("stuck", 1'b0, 1'b1, served, res, cyc);
    checkOutput("stuck_cycles", 32'(cyc), 32'(TIMEOUT + 1));
    stub_stuck = 1'b0;
    wait_engine_idle("post_stuck");

    stub_lat_force = TIMEOUT - 1;
    a_op[1] = 7'd20; b_op[1] = 7'd8;
    req = 4'b0010;
    applyStimulus("tie", 1'b0, 1'b0, served, res, cyc);
    checkOutput("tie_cycles", 32'(cyc), 32'(TIMEOUT + 1));
    checkOutput("tie_value", 32'(res), 32'd4);
    wait_engine_idle("post_tie");

    stub_lat_force = TIMEOUT;
    a_op[2] = 7'd15; b_op[2] = 7'd10;
    req = 4'b0100;
    applyStimulus("late", 1'b0, 1'b1, served, res, cyc);
    checkOutput("late_cycles", 32'(cyc), 32'(TIMEOUT + 1));
    stub_lat_force = 0;
    wait_engine_idle("post_late");

    do_reset();
    a_op[2] = 7'd30; b_op[2] = 7'd12;
    req = 4'b0100;
    applyStimulus("pre_abort", 1'b0, 1'b0, served, res, cyc);
    a_op[3] = 7'd127; b_op[3] = 7'd1;
    req = 4'b1000;
    ok = 1'b0;
    for (int n = 0; n < 20 && !ok; n++) begin
      @(negedge clk);
      ok = (grant != '0) && !eng_start && !eng_ready;
    end
    checkOutput("abort_reached_wait_done", 32'(ok), 32'd1);
    #2 reset = 1'b1;
    #1;
    checkOutput("abort_grant", 32'(grant), 32'd0);
    checkOutput("abort_done", 32'(done), 32'd0);
    checkOutput("abort_busy", 32'(busy), 32'd0);
    checkOutput("abort_start", 32'(eng_start), 32'd0);
    checkOutput("abort_eng_a", 32'(eng_a), 32'd0);
    a_op[2] = 7'd21; b_op[2] = 7'd14;
    req = 4'b1100;
    for (int n = 0; n < 3; n++) begin
      @(negedge clk);
      checkOutput("abort_no_done", 32'(done), 32'd0);
    end
    reset = 1'b0;
    m_rr = 0;
    applyStimulus("post_abort", 1'b0, 1'b0, served, res, cyc);
    checkOutput("post_abort_owner", 32'(served), 32'd2);
    checkOutput("post_abort_value", 32'(res), 32'd7);
    applyStimulus("post_abort_next", 1'b0, 1'b0, served, res, cyc);
    checkOutput("post_abort_next_owner", 32'(served), 32'd3);

    for (int t = 0; t < 40; t++) begin
      for (int i = 0; i < N; i++) begin
        if (!req[i] && ($urandom_range(0, 1) == 1)) begin
          a_op[i] = W'($urandom);
          b_op[i] = W'($urandom);
          req[i] = 1'b1;
        end
      end
      if (req == '0) begin
        a_op[t % N] = W'($urandom);
        b_op[t % N] = W'($urandom);
        req[t % N] = 1'b1;
      end
      applyStimulus("random", 1'b0, 1'b0, served, res, cyc);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
